// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the op and FSM state types plus small decode helpers.
package mult_div_unit_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    // Even encodings are the signed variants, upper bit selects divide.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitude
// and for sign correction of product, quotient and remainder.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    logic signed [W-1:0] val_s;

    assign val_s = $signed(val);
    assign res   = neg ? $unsigned(-val_s) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO.
// Operands are latched as magnitudes; signs are restored in the FIX state.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;

    logic [1:0]         op_q;
    logic               sign_a_q, sign_b_q, b_zero_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc_q;

    logic               sign_a_in, sign_b_in;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept    = (state_q == S_IDLE) && start;
    assign sign_a_in = op_is_signed(op) & src_a[WIDTH-1];
    assign sign_b_in = op_is_signed(op) & src_b[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH)) u_abs_a (.val(src_a), .neg(sign_a_in), .res(abs_a));
    mdu_sign_fix #(.W(WIDTH)) u_abs_b (.val(src_b), .neg(sign_b_in), .res(abs_b));

    // Multiply: acc low half holds the shrinking multiplier, high half the partial sum.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc high half is the remainder, low half shifts dividend out and quotient in.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_trial[WIDTH];
    assign div_next  = {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};

    assign step_next = op_is_div(op_q) ? div_next : mul_next;

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .val(acc_q), .neg(sign_a_q ^ sign_b_q), .res(prod_fix));
    mdu_sign_fix #(.W(WIDTH)) u_fix_quo (
        .val(acc_q[WIDTH-1:0]), .neg(sign_a_q ^ sign_b_q), .res(quo_fix));
    mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
        .val(acc_q[2*WIDTH-1:WIDTH]), .neg(sign_a_q), .res(rem_fix));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == {CNT_W{1'b1}}) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and architectural registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        cnt_q       <= '0;
                        div_by_zero <= 1'b0;
                    end else begin
                        if (mthi) hi <= wr_data;
                        if (mtlo) lo <= wr_data;
                    end
                end
                S_CALC: cnt_q <= cnt_q + CNT_W'(1);
                S_FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (op_is_div(op_q)) begin
                        hi          <= rem_fix;
                        lo          <= b_zero_q ? {WIDTH{1'b1}} : quo_fix;
                        div_by_zero <= b_zero_q;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded on an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= op;
            sign_a_q <= sign_a_in;
            sign_b_q <= sign_b_in;
            b_zero_q <= (src_b == {WIDTH{1'b0}});
            opb_q    <= abs_b;
            acc_q    <= {{WIDTH{1'b0}}, abs_a};
        end else if (state_q == S_CALC) begin
            acc_q <= step_next;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard,
// with hand-written sequences for MTHI/MTLO, busy-time requests and reset abort.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wr_data;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[11];
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done pops one expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                mon_e = sb.pop_front();
                check("hi", {32'd0, hi}, {32'd0, mon_e.hi});
                check("lo", {32'd0, lo}, {32'd0, mon_e.lo});
                check("dbz", {63'd0, div_by_zero}, {63'd0, mon_e.dbz});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the first negedge after the start edge.
    task automatic issue(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        exp_t e;
        start = 1'b1;
        op    = t_op;
        src_a = a;
        src_b = b;
        e.hi = ehi; e.lo = elo; e.dbz = edbz;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        op    = 2'($urandom_range(0, 3));
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_op(input bit inject);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (inject && n == 5) begin
                start   = 1'b1;
                op      = OP_DIVU;
                src_a   = 32'h0000_0064;
                src_b   = 32'h0000_0007;
                mtlo    = 1'b1;
                wr_data = 32'h0000_BEEF;
            end else begin
                start = 1'b0;
                mtlo  = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mtlo  = 1'b0;
        check("busy_len", 64'(n), 64'd33);
        check("done_rise", {63'd0, done}, 64'd1);
        @(negedge clk);
        check("done_pulse", {63'd0, done}, 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0; wr_data = '0;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{OP_MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
        vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{OP_MULT,  32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].edbz);
            wait_op(1'b0);
            check("dbz_hold", {63'd0, div_by_zero}, {63'd0, vecs[i].edbz});
        end

        // MTHI alone, then MTHI+MTLO together.
        mthi = 1'b1; wr_data = 32'h0000_1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", {32'd0, hi}, 64'h0000_1234);
        check("mthi_lo_kept", {32'd0, lo}, 64'hFFFF_FFFB);
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h0000_A5A5;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mtboth_hi", {32'd0, hi}, 64'h0000_A5A5);
        check("mtboth_lo", {32'd0, lo}, 64'h0000_A5A5);

        // Start wins over a same-cycle MTHI.
        mthi = 1'b1; wr_data = 32'h0000_DEAD;
        issue(OP_MULTU, 32'd1, 32'd1, 32'd0, 32'd1, 1'b0);
        check("start_wins_hi", {32'd0, hi}, 64'h0000_A5A5);
        check("start_busy", {63'd0, busy}, 64'd1);
        wait_op(1'b0);

        // Start and MTLO during busy are ignored.
        issue(OP_MULTU, 32'h0001_0001, 32'h0003_0000, 32'h0000_0003, 32'h0003_0000, 1'b0);
        wait_op(1'b1);
        check("inject_lo", {32'd0, lo}, 64'h0003_0000);
        check("inject_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of CALC aborts without touching HI/LO semantics beyond clearing.
        start = 1'b1; op = OP_MULTU; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        rst = 1'b1;
        issue(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0);
        wait_op(1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
